exception_unit: RTL
===================

Name: exception_unit

Overview:
- Precise-exception controller between the MEM stage and the CP0 register file.
- Each cycle it checks the instruction retiring from MEM for exceptions, for pending interrupts (masked by CP0 Status/Cause) and for ERET.
- It then drives the CP0 write-enable vector and data (EPC, BadVAddr, ExcCode, BD, EXL), flushes the pipeline and redirects fetch to the handler or to EPC.
- A small FSM holds off new events until the flush has drained.

Parameters:
- WIDTH, 32, datapath width.
- HANDLER_PC, 32'hBFC00380, exception entry vector.
- FLUSH_CYCLES, 2, cycles the flush is held after the CP0 write cycle (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_valid  in  1  MEM stage holds a real instruction
- mem_pc  in  WIDTH  PC of that instruction
- mem_in_delay_slot  in  1  instruction is in a branch delay slot
- mem_exc_adel_if  in  1  fetch address error
- mem_exc_ri  in  1  reserved instruction
- mem_exc_ov  in  1  arithmetic overflow
- mem_exc_sys  in  1  SYSCALL
- mem_exc_bp  in  1  BREAK
- mem_exc_adel_ld  in  1  load address error
- mem_exc_ades  in  1  store address error
- mem_data_addr  in  WIDTH  load/store virtual address
- mem_eret  in  1  ERET retiring
- hardware_interruption  in  6  asynchronous external interrupt lines
- status_data  in  WIDTH  CP0 Status
- cause_data  in  WIDTH  CP0 Cause
- epc_data  in  WIDTH  CP0 EPC
- cp0_we  out  WIDTH  one-hot-per-register write enables to CP0
- cp0_epc  out  WIDTH  EPC write value
- cp0_badaddr  out  WIDTH  BadVAddr write value
- cp0_exc_code  out  5  Cause.ExcCode write value
- cp0_branch_delay  out  1  Cause.BD write value
- cp0_exl  out  1  Status.EXL write value
- cp0_hw_int  out  6  synchronized interrupt lines for the Cause.IP write
- flush  out  1  kill IF..MEM
- redirect_valid  out  1  fetch must load redirect_pc
- redirect_pc  out  WIDTH  new fetch PC
- busy  out  1  unit is not in IDLE

Behaviour:
- Reset: all outputs 0; FSM goes to IDLE; interrupt synchronizers cleared. Reset taken in any state, including mid-FLUSH, returns to IDLE the next cycle with all outputs 0.
- Interrupt path: hardware_interruption passes through a 2-flop synchronizer, giving hw_sync (2-cycle latency).
  - int_pending = status_data[0] & ~status_data[1] & |({hw_sync, cause_data[9:8]} & status_data[15:8]).
  - An interrupt is taken only when mem_valid=1.
- Event detection, IDLE state only, with mem_valid=1. Priority high to low:
  - Int: code 0x00
  - AdEL (IF): code 0x04, badaddr = mem_pc
  - RI: code 0x0A
  - Ov: code 0x0C
  - Sys: code 0x08
  - Bp: code 0x09
  - AdEL (load): code 0x04, badaddr = mem_data_addr
  - AdES: code 0x05, badaddr = mem_data_addr
  - ERET: lowest priority, only when none of the above fire.
- Exception taken: all outputs below are registered and asserted for exactly one cycle, the cycle after detection. FSM moves IDLE -> WRITE.
  - cp0_we[13]=1 and cp0_we[14]=1. cp0_we[8]=1 only for address errors. cp0_we[12]=1 with cp0_exl=1.
  - cp0_epc = mem_in_delay_slot ? mem_pc-4 (mod 2^WIDTH) : mem_pc.
  - cp0_branch_delay = mem_in_delay_slot.
  - cp0_hw_int = hw_sync.
  - flush=1, redirect_valid=1, redirect_pc=HANDLER_PC.
- ERET taken: the write cycle carries cp0_we[12]=1 with cp0_exl=0 and no other we bits. flush=1, redirect_valid=1, redirect_pc=epc_data sampled at detection.
- WRITE -> FLUSH. FLUSH holds flush=1 for FLUSH_CYCLES cycles via a down-counter, then returns to IDLE. busy=1 in WRITE and FLUSH. redirect_valid is only high in WRITE.
- While busy=1, all mem_* inputs and int_pending are ignored. Nothing is queued; interrupts still pending are re-evaluated in IDLE.
- Any exception together with mem_eret: the exception wins and ERET is discarded.
- Interrupt while Status.EXL=1 or IE=0: not taken. Synchronous exceptions are still taken (EXL is rewritten to 1).
- cp0_we bits other than 8, 12, 13 and 14 are always 0.
- Latency: detection cycle N, CP0 write and redirect at N+1, IDLE again at N+2+FLUSH_CYCLES.

Test Plan:
- Overflow: mem_valid=1, mem_pc=0x80001000, mem_exc_ov=1, not in a delay slot -> next cycle cp0_we has bits 12/13/14 set, cp0_exc_code=0x0C, cp0_epc=0x80001000, cp0_exl=1, redirect_pc=0xBFC00380; flush high for 3 cycles total; busy then drops.
- Delay-slot load AdEL: mem_pc=0x80002004, in slot, data addr 0x80003001 -> cp0_epc=0x80002000, cp0_branch_delay=1, cp0_we[8]=1, cp0_badaddr=0x80003001, code 0x04.
- Interrupt: Status=0x0000_0401, hardware_interruption[0] raised -> taken 2 cycles later on the next mem_valid, code 0x00, cp0_hw_int=6'b000001. Repeat with Status=0x0000_0403 (EXL=1) -> no event.
- Priority: RI+Sys+ERET together -> code 0x0A, redirect to handler, cp0_exl=1. ERET alone with epc_data=0x80000100 -> only cp0_we[12], cp0_exl=0, redirect_pc=0x80000100.
- Busy gating: Sys at N, then Bp at N+1 and N+2 -> only the Sys write occurs. Bp presented again after busy=0 is taken.
- Reset in FLUSH: assert rst at N+2 -> N+3 shows flush=0, busy=0, cp0_we=0; a new Ov after reset is taken normally.

Source files
------------

// File: rtl/exception_unit_if.sv
// ============================================================================
//  Module      : exception_unit_if
//  Description : Bundle between the MEM stage / CP0 side of the pipeline and
//                the precise-exception controller.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface exception_unit_if #(
    parameter int unsigned WIDTH = 32
);
    // Retiring instruction from MEM
    logic             mem_valid;
    logic [WIDTH-1:0] mem_pc;
    logic             mem_in_delay_slot;
    logic             mem_exc_adel_if;
    logic             mem_exc_ri;
    logic             mem_exc_ov;
    logic             mem_exc_sys;
    logic             mem_exc_bp;
    logic             mem_exc_adel_ld;
    logic             mem_exc_ades;
    logic [WIDTH-1:0] mem_data_addr;
    logic             mem_eret;
    // Interrupt lines and CP0 read values
    logic [5:0]       hardware_interruption;
    logic [WIDTH-1:0] status_data;
    logic [WIDTH-1:0] cause_data;
    logic [WIDTH-1:0] epc_data;
    // CP0 write side
    logic [WIDTH-1:0] cp0_we;
    logic [WIDTH-1:0] cp0_epc;
    logic [WIDTH-1:0] cp0_badaddr;
    logic [4:0]       cp0_exc_code;
    logic             cp0_branch_delay;
    logic             cp0_exl;
    logic [5:0]       cp0_hw_int;
    // Pipeline control
    logic             flush;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;
    logic             busy;

    // Pipeline / CP0 side
    modport master (
        output mem_valid, mem_pc, mem_in_delay_slot, mem_exc_adel_if,
               mem_exc_ri, mem_exc_ov, mem_exc_sys, mem_exc_bp,
               mem_exc_adel_ld, mem_exc_ades, mem_data_addr, mem_eret,
               hardware_interruption, status_data, cause_data, epc_data,
        input  cp0_we, cp0_epc, cp0_badaddr, cp0_exc_code, cp0_branch_delay,
               cp0_exl, cp0_hw_int, flush, redirect_valid, redirect_pc, busy
    );

    // Exception controller side
    modport slave (
        input  mem_valid, mem_pc, mem_in_delay_slot, mem_exc_adel_if,
               mem_exc_ri, mem_exc_ov, mem_exc_sys, mem_exc_bp,
               mem_exc_adel_ld, mem_exc_ades, mem_data_addr, mem_eret,
               hardware_interruption, status_data, cause_data, epc_data,
        output cp0_we, cp0_epc, cp0_badaddr, cp0_exc_code, cp0_branch_delay,
               cp0_exl, cp0_hw_int, flush, redirect_valid, redirect_pc, busy
    );
endinterface

`default_nettype wire

// File: rtl/exception_unit.sv
// ============================================================================
//  Module      : exception_unit
//  Description : Precise-exception controller between MEM and CP0. Detects
//                exceptions, masked interrupts and ERET on the retiring
//                instruction, writes CP0, flushes and redirects fetch.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module exception_unit #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] HANDLER_PC   = 'hBFC00380,
    parameter int unsigned      FLUSH_CYCLES = 2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    exception_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [4:0] c_CODE_INT  = 5'h00;
    localparam logic [4:0] c_CODE_ADEL = 5'h04;
    localparam logic [4:0] c_CODE_ADES = 5'h05;
    localparam logic [4:0] c_CODE_SYS  = 5'h08;
    localparam logic [4:0] c_CODE_BP   = 5'h09;
    localparam logic [4:0] c_CODE_RI   = 5'h0A;
    localparam logic [4:0] c_CODE_OV   = 5'h0C;

    localparam int unsigned c_WE_BADVADDR = 8;
    localparam int unsigned c_WE_STATUS   = 12;
    localparam int unsigned c_WE_CAUSE    = 13;
    localparam int unsigned c_WE_EPC      = 14;

    localparam logic [3:0] c_FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [5:0]       hw_meta_q, hw_sync_q;

    logic [WIDTH-1:0] we_q, we_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [WIDTH-1:0] badaddr_q, badaddr_d;
    logic [4:0]       code_q, code_d;
    logic             bd_q, bd_d;
    logic             exl_q, exl_d;
    logic [5:0]       hw_int_q, hw_int_d;
    logic             flush_q, flush_d;
    logic             redir_valid_q, redir_valid_d;
    logic [WIDTH-1:0] redir_pc_q, redir_pc_d;
    logic             busy_q, busy_d;

    logic [7:0]       int_lines;
    logic             int_pending;
    logic             exc_any;
    logic             addr_err;
    logic [4:0]       exc_code;
    logic [WIDTH-1:0] exc_badaddr;

    // Only IE, EXL and the IP/IM byte lanes matter to this unit
    logic unused_ok;
    assign unused_ok = ^{bus.status_data[WIDTH-1:16], bus.status_data[7:2],
                         bus.cause_data[WIDTH-1:10], bus.cause_data[7:0]};

    // Two-flop synchronizer for the asynchronous interrupt lines
    always_ff @(posedge clk) begin
        if (rst) begin
            hw_meta_q <= '0;
            hw_sync_q <= '0;
        end else begin
            hw_meta_q <= bus.hardware_interruption;
            hw_sync_q <= hw_meta_q;
        end
    end

    assign int_lines   = {hw_sync_q, bus.cause_data[9:8]} & bus.status_data[15:8];
    assign int_pending = bus.status_data[0] & ~bus.status_data[1] & (|int_lines);

    assign exc_any = int_pending | bus.mem_exc_adel_if | bus.mem_exc_ri |
                     bus.mem_exc_ov | bus.mem_exc_sys | bus.mem_exc_bp |
                     bus.mem_exc_adel_ld | bus.mem_exc_ades;

    // Priority encode the winning exception cause and its bad address
    always_comb begin
        exc_code    = c_CODE_INT;
        exc_badaddr = '0;
        addr_err    = 1'b0;
        if (int_pending) begin
            exc_code = c_CODE_INT;
        end else if (bus.mem_exc_adel_if) begin
            exc_code    = c_CODE_ADEL;
            exc_badaddr = bus.mem_pc;
            addr_err    = 1'b1;
        end else if (bus.mem_exc_ri) begin
            exc_code = c_CODE_RI;
        end else if (bus.mem_exc_ov) begin
            exc_code = c_CODE_OV;
        end else if (bus.mem_exc_sys) begin
            exc_code = c_CODE_SYS;
        end else if (bus.mem_exc_bp) begin
            exc_code = c_CODE_BP;
        end else if (bus.mem_exc_adel_ld) begin
            exc_code    = c_CODE_ADEL;
            exc_badaddr = bus.mem_data_addr;
            addr_err    = 1'b1;
        end else if (bus.mem_exc_ades) begin
            exc_code    = c_CODE_ADES;
            exc_badaddr = bus.mem_data_addr;
            addr_err    = 1'b1;
        end
    end

    // Next state and next registered outputs; outputs default to zero so
    // every CP0 write and redirect is a single-cycle pulse
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        we_d          = '0;
        epc_d         = '0;
        badaddr_d     = '0;
        code_d        = '0;
        bd_d          = 1'b0;
        exl_d         = 1'b0;
        hw_int_d      = '0;
        flush_d       = 1'b0;
        redir_valid_d = 1'b0;
        redir_pc_d    = '0;
        busy_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.mem_valid && (exc_any || bus.mem_eret)) begin
                    state_d       = ST_WRITE;
                    flush_d       = 1'b1;
                    redir_valid_d = 1'b1;
                    busy_d        = 1'b1;
                    we_d[c_WE_STATUS] = 1'b1;
                    if (exc_any) begin
                        we_d[c_WE_CAUSE]    = 1'b1;
                        we_d[c_WE_EPC]      = 1'b1;
                        we_d[c_WE_BADVADDR] = addr_err;
                        exl_d      = 1'b1;
                        epc_d      = bus.mem_in_delay_slot ? (bus.mem_pc - WIDTH'(4))
                                                           : bus.mem_pc;
                        bd_d       = bus.mem_in_delay_slot;
                        badaddr_d  = exc_badaddr;
                        code_d     = exc_code;
                        hw_int_d   = hw_sync_q;
                        redir_pc_d = HANDLER_PC;
                    end else begin
                        // ERET: clear EXL and return to the saved EPC
                        redir_pc_d = bus.epc_data;
                    end
                end
            end
            ST_WRITE: begin
                state_d = ST_FLUSH;
                cnt_d   = c_FLUSH_LOAD;
                flush_d = 1'b1;
                busy_d  = 1'b1;
            end
            ST_FLUSH: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    flush_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, flush counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            we_q          <= '0;
            epc_q         <= '0;
            badaddr_q     <= '0;
            code_q        <= '0;
            bd_q          <= 1'b0;
            exl_q         <= 1'b0;
            hw_int_q      <= '0;
            flush_q       <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            we_q          <= we_d;
            epc_q         <= epc_d;
            badaddr_q     <= badaddr_d;
            code_q        <= code_d;
            bd_q          <= bd_d;
            exl_q         <= exl_d;
            hw_int_q      <= hw_int_d;
            flush_q       <= flush_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.cp0_we           = we_q;
    assign bus.cp0_epc          = epc_q;
    assign bus.cp0_badaddr      = badaddr_q;
    assign bus.cp0_exc_code     = code_q;
    assign bus.cp0_branch_delay = bd_q;
    assign bus.cp0_exl          = exl_q;
    assign bus.cp0_hw_int       = hw_int_q;
    assign bus.flush            = flush_q;
    assign bus.redirect_valid   = redir_valid_q;
    assign bus.redirect_pc      = redir_pc_q;
    assign bus.busy             = busy_q;

endmodule

`default_nettype wire
